// File: rtl/aegis_pkg.sv
// rtl/aegis_pkg.sv - shared states, bus field positions and park word for the AegisX host driver
package aegis_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, COMP, HOLD, SAMPLE, DONE} state_t;

  localparam int START_BIT = 4;
  localparam int MODE_BIT  = 5;
  localparam int NIBBLE_W  = 4;
  localparam int NIBBLES   = 16;

  localparam logic [7:0] PARK = 8'h10;

  function automatic logic [7:0] drv_word(input logic mode, input logic start,
                                          input logic [NIBBLE_W-1:0] nib);
    logic [7:0] w;
    w = 8'h00;
    w[MODE_BIT]  = mode;
    w[START_BIT] = start;
    w[NIBBLE_W-1:0] = nib;
    return w;
  endfunction

endpackage

// File: rtl/aegis_nibble_sel.sv
// rtl/aegis_nibble_sel.sv - combinational 64-to-4 nibble selector, MSB-first or LSB-first order
module aegis_nibble_sel
  import aegis_pkg::*;
(
  input  logic [63:0]         word,
  input  logic [3:0]          index,
  input  logic                msb_first,
  output logic [NIBBLE_W-1:0] nibble
);

  logic [3:0] w_pos;

  assign w_pos  = msb_first ? (4'(NIBBLES - 1) - index) : index;
  assign nibble = word[{w_pos, 2'b00} +: NIBBLE_W];

endmodule

// File: rtl/aegis_x_host_driver.sv
// rtl/aegis_x_host_driver.sv - serialises an operand pair onto the engine control bus and returns the result byte
module aegis_x_host_driver
  import aegis_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int NIBBLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic        op_mode,
  output logic [7:0]  drv_out,
  input  logic [7:0]  res_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_byte
);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_a, r_b;
  logic        r_mode;
  logic [7:0]  r_drv, w_drv_nxt;
  logic        r_res_valid, w_res_valid_nxt;
  logic [7:0]  r_res_byte, w_res_byte_nxt;
  logic        w_capture;
  logic [3:0]  w_idx;
  logic [3:0]  w_a_nib, w_b_nib;

  // Nibble 0 of each operand is driven on the transition edge, so the counter looks one ahead.
  assign w_idx = r_cnt[3:0] + 4'd1;

  aegis_nibble_sel u_sel_a (
    .word      (r_a),
    .index     (w_idx),
    .msb_first (1'b1),
    .nibble    (w_a_nib)
  );

  aegis_nibble_sel u_sel_b (
    .word      (r_b),
    .index     (w_idx),
    .msb_first (1'b0),
    .nibble    (w_b_nib)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_drv_nxt       = r_drv;
    w_res_valid_nxt = r_res_valid;
    w_res_byte_nxt  = r_res_byte;
    w_capture       = 1'b0;
    case (r_state)
      IDLE: begin
        if (op_valid) begin
          w_capture   = 1'b1;
          w_drv_nxt   = drv_word(op_mode, 1'b0, op_a[63:60]);
          w_cnt_nxt   = 5'd0;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_cnt_nxt = r_cnt + 5'd1;
        w_drv_nxt = drv_word(r_mode, 1'b0, w_a_nib);
        if (r_cnt == 5'(NIBBLES - 1)) begin
          w_drv_nxt   = drv_word(r_mode, 1'b1, r_b[3:0]);
          w_cnt_nxt   = 5'd0;
          w_state_nxt = COMP;
        end
      end
      COMP: begin
        w_cnt_nxt = r_cnt + 5'd1;
        w_drv_nxt = drv_word(r_mode, 1'b1, w_b_nib);
        if (r_cnt == 5'(NIBBLES - 1)) begin
          w_drv_nxt   = drv_word(r_mode, 1'b1, 4'h0);
          w_cnt_nxt   = 5'd0;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_cnt_nxt = r_cnt + 5'd1;
        if (r_cnt == 5'(SETTLE - 1)) begin
          w_cnt_nxt   = 5'd0;
          w_state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        w_res_byte_nxt  = res_in;
        w_res_valid_nxt = 1'b1;
        w_state_nxt     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 5'd0;
      r_a         <= 64'd0;
      r_b         <= 64'd0;
      r_mode      <= 1'b0;
      r_drv       <= PARK;
      r_res_valid <= 1'b0;
      r_res_byte  <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_drv       <= w_drv_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_byte  <= w_res_byte_nxt;
      if (w_capture) begin
        r_a    <= op_a;
        r_b    <= op_b;
        r_mode <= op_mode;
      end
    end
  end

  assign op_ready  = (r_state == IDLE);
  assign drv_out   = r_drv;
  assign res_valid = r_res_valid;
  assign res_byte  = r_res_byte;

endmodule

// File: tb/tb_aegis_x_host_driver.sv
// tb/tb_aegis_x_host_driver.sv - self-checking bench for aegis_x_host_driver with a behavioural engine
module tb_aegis_x_host_driver;

  localparam int SETTLE = 2;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        op_mode;
  logic [7:0]  drv_out;
  logic [7:0]  res_in;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_byte;

  int n_pass  = 0;
  int n_total = 0;

  logic [127:0] ref_acc;

  aegis_x_host_driver #(.SETTLE(SETTLE), .NIBBLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_mode   (op_mode),
    .drv_out   (drv_out),
    .res_in    (res_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_byte  (res_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine: start=0 shifts a nibble into A; start=1 adds A * nibble at the next nibble weight, 16 steps max.
  logic [63:0]  e_a;
  logic [127:0] e_acc;
  logic [4:0]   e_step;

  always @(posedge clk) begin
    if (rst) begin
      e_a    <= 64'd0;
      e_acc  <= 128'd0;
      e_step <= 5'd16;
    end else if (!drv_out[4]) begin
      e_a    <= {e_a[59:0], drv_out[3:0]};
      e_step <= 5'd0;
    end else if (e_step < 5'd16) begin
      e_acc  <= e_acc + ((128'(e_a) * 128'(drv_out[3:0])) << (4 * e_step));
      e_step <= e_step + 5'd1;
    end
  end

  assign res_in = e_acc[7:0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_drv(input logic [63:0] a, input logic [63:0] b,
                                         input logic m, input int k);
    logic [3:0] nib;
    if (k < 16) begin
      nib = 4'((a >> (60 - 4 * k)) & 64'hF);
      return {2'b00, m, 1'b0, nib};
    end else if (k < 32) begin
      nib = 4'((b >> (4 * (k - 16))) & 64'hF);
      return {2'b00, m, 1'b1, nib};
    end
    return {2'b00, m, 1'b1, 4'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    ref_acc = 128'd0;
    tick();
    check("reset_drv", 64'(drv_out), 64'h10);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_res_byte", 64'(res_byte), 64'd0);
    check("reset_op_ready", 64'(op_ready), 64'd1);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic m,
                        input int stall, output logic [7:0] got);
    int t, first, bad, bad2;
    t = 0;
    while (!op_ready && t < 100) begin tick(); t++; end
    check("op_ready_idle", 64'(op_ready), 64'd1);
    op_a = a; op_b = b; op_mode = m; op_valid = 1'b1; res_ready = 1'b0;
    tick();
    op_valid = 1'b0;
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; op_mode = ~m;
    first = -1; bad = 0;
    for (int k = 0; k < 60 && first < 0; k++) begin
      if (k > 0) tick();
      if (res_valid) first = k;
      else begin
        if (drv_out !== exp_drv(a, b, m, k)) bad++;
        if (op_ready !== 1'b0) bad++;
      end
    end
    check("drv_seq", 64'(bad), 64'd0);
    check("latency", 64'(first), 64'(33 + SETTLE));
    got = res_byte;
    bad2 = 0;
    for (int s = 0; s < stall; s++) begin
      if (s == 5) begin op_valid = 1'b1; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; end
      if (s == 6) op_valid = 1'b0;
      tick();
      if (res_valid !== 1'b1 || res_byte !== got || op_ready !== 1'b0 ||
          drv_out !== exp_drv(a, b, m, 40)) bad2++;
    end
    op_valid = 1'b0;
    if (stall > 0) check("stall_stable", 64'(bad2), 64'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("handshake_res_valid", 64'(res_valid), 64'd0);
    check("handshake_op_ready", 64'(op_ready), 64'd1);
    check("idle_park", 64'(drv_out), 64'(exp_drv(a, b, m, 40)));
  endtask

  typedef struct {
    logic        rst_before;
    logic [63:0] a;
    logic [63:0] b;
    logic        m;
    int          stall;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0]  got;
    logic [63:0] ra, rb;
    logic        rm;
    vecs[0] = '{1'b1, 64'h3,  64'h5,  1'b0, 0,  8'h0F};
    vecs[1] = '{1'b0, 64'h2,  64'h4,  1'b0, 0,  8'h17};
    vecs[2] = '{1'b1, 64'hFF, 64'hFF, 1'b0, 0,  8'h01};
    vecs[3] = '{1'b1, 64'h1,  64'h1,  1'b1, 0,  8'h01};
    vecs[4] = '{1'b0, 64'h7,  64'h9,  1'b0, 20, 8'h40};

    rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; op_mode = 1'b0; res_ready = 1'b0;
    ref_acc = 128'd0;
    do_reset();

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].rst_before) do_reset();
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].stall, got);
      ref_acc = ref_acc + 128'(vecs[i].a) * 128'(vecs[i].b);
      check("vec_res_byte", 64'(got), 64'(vecs[i].exp));
    end

    // Reset in the middle of LOAD, then a fresh operation.
    op_a = 64'h0123_4567_89AB_CDEF; op_b = 64'h11; op_mode = 1'b1; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("midload_drv", 64'(drv_out), 64'h10);
    check("midload_res_valid", 64'(res_valid), 64'd0);
    check("midload_op_ready", 64'(op_ready), 64'd1);
    rst = 1'b0;
    ref_acc = 128'd0;
    run_op(64'h6, 64'h7, 1'b0, 0, got);
    ref_acc = ref_acc + 128'd42;
    check("midload_fresh_res", 64'(got), 64'h2A);

    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rm = 1'($urandom_range(0, 1));
      run_op(ra, rb, rm, int'($urandom_range(0, 3)), got);
      ref_acc = ref_acc + 128'(ra) * 128'(rb);
      check("rand_res_byte", 64'(got), 64'(ref_acc[7:0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aegis_x_host_driver.md
Name: aegis_x_host_driver

Overview:
Host-side transmitter for the AegisXTurbo nibble-serial multiply port. It accepts a 64-bit operand pair over a valid/ready handshake and serialises it onto the 8-bit control bus of the engine: 16 load cycles for A, then 16 compute cycles for B. It waits a settle time, samples the engine's result byte, and returns it over a second valid/ready handshake. It sits between a host/bench sequencer and the engine's ui_in/uo_out pins.

Parameters:
SETTLE, 2, cycles held in HOLD before sampling res_in (min 1; covers driver register plus engine accumulate edge)
NIBBLES, 16, nibbles per 64-bit operand (fixed; exists for readability only)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
op_valid  in  1  operand pair valid
op_ready  out  1  driver can accept; high only in IDLE
op_a  in  64  multiplicand; serialised MSB nibble first
op_b  in  64  multiplier; serialised LSB nibble first
op_mode  in  1  captured with operands; driven on drv_out[5] for the whole op
drv_out  out  8  to engine ui_in: [3:0] nibble, [4] start, [5] mode, [7:6] zero
res_in  in  8  from engine uo_out (low byte of engine accumulator)
res_valid  out  1  result byte available
res_ready  in  1  consumer accepts result
res_byte  out  8  sampled res_in

Behaviour:
- Reset (rst=1 at edge): state=IDLE, drv_out=8'h10 (park: start=1, nibble 0, mode 0), res_valid=0, res_byte=0, counters=0. op_ready is combinational from state, so it is 1 in the cycle after reset.
- drv_out is fully registered. No combinational path from inputs to drv_out.
- States:
  - IDLE: drv_out=park with the last mode. op_ready=1. When op_valid & op_ready: capture a, b and mode; drv_out <= {2'b0, mode, 0, a[63:60]}; cnt <= 0; go to LOAD.
  - LOAD: on each edge cnt++ and drv_out presents a[63-4k -: 4] with start=0. After 16 nibbles (cnt==15 at the edge): drv_out <= {.., start=1, b[3:0]}; cnt <= 0; go to COMP.
  - COMP: on each edge drv_out presents b[4k+3:4k] with start=1. After 16 nibbles: drv_out <= park (start=1, nibble 0); cnt <= 0; go to HOLD.
  - HOLD: the engine step counter is saturated at 16, so its accumulator is frozen. After SETTLE cycles, go to SAMPLE.
  - SAMPLE: one cycle. res_byte <= res_in; res_valid <= 1; go to DONE.
  - DONE: hold res_valid and res_byte stable until res_valid & res_ready. On that edge: res_valid <= 0; go to IDLE.
- Timing: accept edge E0. First compute nibble is driven at E16. Park is driven at E32. res_valid rises at E(33+SETTLE). With the default SETTLE=2, that is 35 cycles.
- Arithmetic: none in the driver. The engine accumulator is never cleared except by engine reset. res_byte is therefore (previous_acc + A*B)[7:0]; the driver reports it raw.
- op_valid while busy: ignored; op_ready=0. Operands are captured only on the accept edge; later changes to op_a/op_b have no effect.
- res_ready held low: the driver stalls in DONE indefinitely with drv_out parked. No new op is accepted.
- Reset mid-op: rst wins over every state transition and returns the driver to reset values. The engine must be reset concurrently for a consistent accumulator; the driver does not enforce this.
- IDLE never drives start=0, so engine reg_a is never disturbed between ops.

Decomposition:
- Shared package aegis_pkg holds:
  - state enum {IDLE, LOAD, COMP, HOLD, SAMPLE, DONE}
  - START_BIT=4, MODE_BIT=5, NIBBLE_W=4, NIBBLES=16
  - park constant 8'h10
- One natural sub-module: aegis_nibble_sel. It is a combinational 64-to-4 selector with inputs word, index and msb_first. It is used for both A (msb_first=1) and B (msb_first=0).
- FSM, counters and result register stay in the top module.

Test Plan:
- Reset, then a=64'h3, b=64'h5, mode=0 -> LOAD drives fifteen 0-nibbles then 3; COMP drives 5 then zeros; res_valid rises 35 cycles after accept; res_byte=8'h0F.
- Without reset, follow with a=64'h2, b=64'h4 -> res_byte=8'h17 (accumulated 15+8).
- Reset, then a=64'hFF, b=64'hFF -> res_byte=8'h01 (0xFE01 low byte); drv_out[5]=0 throughout.
- mode=1, a=64'h1, b=64'h1 -> drv_out[5]=1 through LOAD/COMP/HOLD; res_byte=8'h01.
- Hold res_ready=0 for 20 cycles after res_valid -> res_valid and res_byte stable, op_ready=0, a pulsed op_valid is ignored; op accepted only after res_ready handshake.
- Assert rst at cycle 10 of LOAD -> next cycle drv_out=8'h10, res_valid=0, op_ready=1; a fresh op then produces the correct result.
